// File: rtl/common_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : common_bus_pkg
//  Purpose  : Shared opcode, ALU-op, bus-select and FSM-state encodings for
//             the common-bus CPU core, plus small decode helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package common_bus_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDI = 4'd1,
      OP_SUB  = 4'd2,
      OP_XOR  = 4'd3,
      OP_NAND = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_NOR  = 4'd8,
      OP_BEQ  = 4'd9,
      OP_HALT = 4'd15
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_XOR  = 3'd2,
      ALU_NAND = 3'd3,
      ALU_SLL  = 3'd4,
      ALU_SRL  = 3'd5,
      ALU_SRA  = 3'd6,
      ALU_NOR  = 3'd7
   } alu_op_t;

   typedef enum logic [3:0] {
      BUS_PC      = 4'd0,
      BUS_PC_NEXT = 4'd1,
      BUS_IR_R1   = 4'd2,
      BUS_IR_R2   = 4'd3,
      BUS_IR_RD   = 4'd4,
      BUS_IMM     = 4'd5,
      BUS_ALU     = 4'd6,
      BUS_RF      = 4'd7,
      BUS_NOP     = 4'd8
   } bus_sel_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_RDA    = 3'd2,
      S_RDB    = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_PCUP   = 3'd6,
      S_HALT   = 3'd7
   } cpu_state_t;

   // Opcodes 10..14 are reserved and execute as no-operations.
   function automatic logic is_nop_op(input logic [3:0] op);
      return (op >= 4'd10) && (op <= 4'd14);
   endfunction

   // ADDI and BEQ share the adder; BEQ ignores the ALU result.
   function automatic alu_op_t alu_op_of(input logic [3:0] op);
      alu_op_t r;
      r = ALU_ADD;
      case (op)
         OP_SUB:  r = ALU_SUB;
         OP_XOR:  r = ALU_XOR;
         OP_NAND: r = ALU_NAND;
         OP_SLL:  r = ALU_SLL;
         OP_SRL:  r = ALU_SRL;
         OP_SRA:  r = ALU_SRA;
         OP_NOR:  r = ALU_NOR;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/common_bus_cpu_core_alu.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_alu
//  Purpose  : Combinational DATA_W-bit ALU (add/sub/logic/shifts), no flags.
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_alu
   import common_bus_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  alu_op_t            op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   output logic [DATA_W-1:0]  y
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] sh;

   assign sh = b[SH_W-1:0];

   // Result selection; all arithmetic wraps modulo 2^DATA_W.
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_XOR:  y = a ^ b;
         ALU_NAND: y = ~(a & b);
         ALU_SLL:  y = a << sh;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $signed(a) >>> sh;
         ALU_NOR:  y = ~(a | b);
         default:  y = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/common_bus_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : common_bus_cpu_core
//  Purpose  : Multi-cycle common-bus CPU core. One bus transfer per cycle,
//             sequenced by FETCH/DECODE/RDA/RDB/EXEC/WB/PCUP, with an
//             instruction-fetch handshake, hardwired-zero R0, BEQ and HALT.
//  Revision : 1.0 - initial release
// ============================================================================
module common_bus_cpu_core
   import common_bus_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 8,
   parameter  int PC_W     = 8,
   localparam int RA       = $clog2(NUM_REGS),
   localparam int INSTR_W  = 4 + 3*RA
)(
   input  logic                clock,
   input  logic                reset_n,
   output logic                instr_req,
   output logic [PC_W-1:0]     instr_addr,
   input  logic                instr_valid,
   input  logic [INSTR_W-1:0]  instr_data,
   input  logic [RA-1:0]       dbg_sel,
   output logic [DATA_W-1:0]   dbg_data,
   output logic [PC_W-1:0]     pc,
   output logic                retire,
   output logic                halted
);

   localparam int BUS_W = (DATA_W > PC_W) ? DATA_W : PC_W;

   cpu_state_t           state;
   logic [INSTR_W-1:0]   ir;
   logic [DATA_W-1:0]    a_q;
   logic [DATA_W-1:0]    b_q;
   logic [DATA_W-1:0]    res_q;
   logic [DATA_W-1:0]    regs [NUM_REGS];

   logic [3:0]           ir_op;
   logic [RA-1:0]        ir_rs2;
   logic [RA-1:0]        ir_rs1;
   logic [RA-1:0]        ir_rd;
   bus_sel_t             bus_sel;
   logic [BUS_W-1:0]     bus;
   logic [DATA_W-1:0]    alu_y;
   alu_op_t              alu_op;
   logic                 beq_taken;
   logic [PC_W-1:0]      pc_next;

   assign ir_op  = ir[3:0];
   assign ir_rs2 = ir[4 +: RA];
   assign ir_rs1 = ir[4+RA +: RA];
   assign ir_rd  = ir[4+2*RA +: RA];

   // R0 reads as zero regardless of storage contents.
   function automatic logic [DATA_W-1:0] rf_read(input logic [RA-1:0] idx);
      return (idx == '0) ? '0 : regs[idx];
   endfunction

   assign dbg_data   = rf_read(dbg_sel);
   assign instr_addr = pc;

   // A and B still hold the compared operands when PCUP runs.
   assign beq_taken = (ir_op == OP_BEQ) && (a_q == b_q);
   assign pc_next   = beq_taken ? (pc + PC_W'($signed(ir_rd))) : (pc + PC_W'(1));

   assign alu_op = alu_op_of(ir_op);

   cbus_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op (alu_op),
      .a  (a_q),
      .b  (b_q),
      .y  (alu_y)
   );

   // Select the single bus source for the current micro-step.
   always_comb begin
      bus_sel = BUS_NOP;
      case (state)
         S_RDA:   bus_sel = BUS_IR_R1;
         S_RDB:   bus_sel = (ir_op == OP_ADDI) ? BUS_IMM : BUS_IR_R2;
         S_EXEC:  bus_sel = BUS_ALU;
         S_WB:    bus_sel = BUS_RF;
         S_PCUP:  bus_sel = BUS_PC_NEXT;
         default: bus_sel = BUS_NOP;
      endcase
   end

   // Drive the common bus from the selected source, zero-extended.
   always_comb begin
      bus = '0;
      case (bus_sel)
         BUS_PC:      bus = BUS_W'(pc);
         BUS_PC_NEXT: bus = BUS_W'(pc_next);
         BUS_IR_R1:   bus = BUS_W'(rf_read(ir_rs1));
         BUS_IR_R2:   bus = BUS_W'(rf_read(ir_rs2));
         BUS_IR_RD:   bus = BUS_W'(rf_read(ir_rd));
         BUS_IMM:     bus = BUS_W'(DATA_W'(ir_rs2));
         BUS_ALU:     bus = BUS_W'(alu_y);
         BUS_RF:      bus = BUS_W'(res_q);
         default:     bus = '0;
      endcase
   end

   // Microcode sequencer with registered handshake/status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_FETCH;
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         pc        <= '0;
         retire    <= 1'b0;
         halted    <= 1'b0;
         instr_req <= 1'b1;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               if (instr_req && instr_valid) begin
                  ir        <= instr_data;
                  instr_req <= 1'b0;
                  state     <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (ir_op == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  retire <= 1'b1;
               end else if (is_nop_op(ir_op)) begin
                  state  <= S_PCUP;
                  retire <= 1'b1;
               end else begin
                  state  <= S_RDA;
               end
            end
            S_RDA: begin
               a_q   <= bus[DATA_W-1:0];
               state <= S_RDB;
            end
            S_RDB: begin
               b_q   <= bus[DATA_W-1:0];
               state <= S_EXEC;
            end
            S_EXEC: begin
               res_q <= bus[DATA_W-1:0];
               if (ir_op == OP_BEQ) begin
                  state  <= S_PCUP;
                  retire <= 1'b1;
               end else begin
                  state  <= S_WB;
               end
            end
            S_WB: begin
               state  <= S_PCUP;
               retire <= 1'b1;
            end
            S_PCUP: begin
               pc        <= bus[PC_W-1:0];
               instr_req <= 1'b1;
               state     <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state     <= S_FETCH;
               instr_req <= 1'b1;
            end
         endcase
      end
   end

   // Register file write-back; writes addressed to R0 are dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if ((state == S_WB) && (ir_rd != '0)) begin
         regs[ir_rd] <= bus[DATA_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_common_bus_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_common_bus_cpu_core
//  Purpose  : Scoreboard bench for common_bus_cpu_core: directed programs and
//             random instructions against an architectural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_common_bus_cpu_core;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int RA = 3;
   localparam int PW = 8;
   localparam int IW = 4 + 3*RA;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic           instr_req;
   logic [PW-1:0]  instr_addr;
   logic           instr_valid = 1'b0;
   logic [IW-1:0]  instr_data = '0;
   logic [RA-1:0]  dbg_sel = '0;
   logic [DW-1:0]  dbg_data;
   logic [PW-1:0]  pc;
   logic           retire;
   logic           halted;

   common_bus_cpu_core #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .PC_W     (PW)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data),
      .pc          (pc),
      .retire      (retire),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int acc;
      int lat;
      int npc;
      int rd;
      int rd_val;
      bit halt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   rcount = 0;
   int   m_reg[NR];
   int   m_pc;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic summary_and_end();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < NR; i++) m_reg[i] = 0;
   endtask

   function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int rs2);
      logic [3:0] o;
      logic [2:0] d, s1, s2;
      o = op[3:0]; d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
      return {d, s1, s2, o};
   endfunction

   // Architectural effect of one instruction, from the instruction-set rules.
   task automatic model_exec(input logic [IW-1:0] ins, output exp_t e);
      int op, rs2, rs1, rd, a, b, sh, res, sa, off;
      op = int'(ins[3:0]); rs2 = int'(ins[6:4]); rs1 = int'(ins[9:7]); rd = int'(ins[12:10]);
      a = m_reg[rs1]; b = m_reg[rs2]; sh = b % 8; res = 0;
      e.halt = 0; e.lat = 6; e.npc = (m_pc + 1) % 256;
      case (op)
         0: res = a + b;
         1: res = a + rs2;
         2: res = a - b;
         3: res = a ^ b;
         4: res = ~(a & b);
         5: res = a << sh;
         6: res = a >> sh;
         7: begin sa = (a > 127) ? a - 256 : a; res = sa >>> sh; end
         8: res = ~(a | b);
         9: begin
            e.lat = 5;
            off = (rd > 3) ? rd - 8 : rd;
            if (a == b) e.npc = (m_pc + off + 256) % 256;
         end
         15: begin e.halt = 1; e.lat = 2; e.npc = m_pc; end
         default: e.lat = 2;
      endcase
      if (op <= 8 && rd != 0) m_reg[rd] = res & 255;
      e.rd = rd;
      e.rd_val = m_reg[rd];
      m_pc = e.npc;
   endtask

   // Present one instruction after 'stall' idle FETCH cycles and log its expectation.
   task automatic issue(input logic [IW-1:0] ins, input int stall);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clock);
      while (instr_req !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (instr_req !== 1'b1) begin
         n_cmp++; n_fail++;
         $display("FAIL fetch_timeout: got instr_req=%b, expected 1 within 100 cycles", instr_req);
         summary_and_end();
      end
      for (int s = 0; s < stall; s++) begin
         instr_valid = 1'b0;
         chk("stall_req", int'(instr_req), 1);
         chk("stall_addr", int'(instr_addr), m_pc);
         @(negedge clock);
      end
      chk("fetch_addr", int'(instr_addr), m_pc);
      instr_valid = 1'b1;
      instr_data  = ins;
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      instr_data  = IW'($urandom);
      model_exec(ins, e);
      e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clock);
         t++;
      end
      chk("drain_queue", exp_q.size(), 0);
      repeat (3) @(negedge clock);
   endtask

   // Monitor: on every retire, pop the oldest expectation and compare.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (retire === 1'b1) begin
            rcount++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_retire: got retire=1, expected no pending instruction");
            end else begin
               e = exp_q.pop_front();
               chk("retire_latency", cyc - e.acc, e.lat - 1);
               if (e.halt) begin
                  chk("halt_flag", int'(halted), 1);
                  chk("halt_req", int'(instr_req), 0);
               end else begin
                  dbg_sel = e.rd[RA-1:0];
                  #1;
                  chk("rd_value", int'(dbg_data), e.rd_val);
                  @(posedge clock);
                  #1;
                  chk("next_pc", int'(pc), e.npc);
               end
            end
         end
      end
   end

   initial begin : driver
      int r0;
      int op;
      model_reset();
      repeat (3) @(negedge clock);
      chk("reset_pc", int'(pc), 0);
      chk("reset_req", int'(instr_req), 1);
      chk("reset_retire", int'(retire), 0);
      chk("reset_halted", int'(halted), 0);
      for (int i = 0; i < NR; i++) begin
         dbg_sel = i[RA-1:0];
         #1;
         chk("reset_reg", int'(dbg_data), 0);
      end
      @(negedge clock);
      reset_n = 1'b1;

      // Directed: first ADDI, stalled fetch, shift/logic chain, R0 write.
      issue(enc(1, 1, 0, 5), 0);
      issue(enc(1, 2, 0, 5), 3);
      issue(enc(1, 1, 0, 1), 0);
      issue(enc(1, 2, 0, 7), 1);
      issue(enc(5, 3, 1, 2), 0);
      issue(enc(7, 4, 3, 1), 0);
      issue(enc(6, 5, 3, 1), 2);
      issue(enc(4, 6, 1, 1), 0);
      issue(enc(2, 7, 1, 2), 0);
      issue(enc(1, 0, 0, 5), 0);

      // Directed branches: walk pc to 4, taken backward, not taken, wrap to 0xFF and back to 0.
      issue(enc(9, 4, 0, 0), 0);
      issue(enc(9, 6, 0, 0), 0);
      issue(enc(9, 7, 1, 1), 0);
      issue(enc(9, 1, 1, 1), 0);
      issue(enc(9, 7, 1, 2), 0);
      issue(enc(9, 4, 0, 0), 0);
      issue(enc(9, 7, 0, 0), 0);
      issue(enc(9, 7, 0, 0), 0);
      issue(enc(9, 3, 1, 2), 1);
      issue(enc(12, 5, 2, 3), 0);

      // Random instruction stream (no HALT) with random fetch stalls.
      for (int n = 0; n < 150; n++) begin
         op = int'($urandom_range(0, 14));
         issue(enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7))),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      drain();

      // HALT: exactly one retire, then parked with no fetch request.
      r0 = rcount;
      issue(enc(15, 0, 0, 0), 0);
      @(negedge clock);
      repeat (20) begin
         @(negedge clock);
         chk("halted_hold", int'(halted), 1);
         chk("halted_req", int'(instr_req), 0);
      end
      chk("halt_retires", rcount - r0, 1);
      chk("halt_queue", exp_q.size(), 0);
      for (int i = 0; i < NR; i++) begin
         dbg_sel = i[RA-1:0];
         #1;
         chk("final_reg", int'(dbg_data), m_reg[i]);
      end

      // Reset out of HALT, then reset again in the middle of EXEC.
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("halt_reset_halted", int'(halted), 0);
      chk("halt_reset_req", int'(instr_req), 1);
      @(negedge clock);
      reset_n = 1'b1;
      issue(enc(1, 1, 0, 6), 0);
      issue(enc(0, 2, 1, 1), 1);
      repeat (3) @(posedge clock);
      #2;
      chk("pre_reset_no_retire", int'(retire), 0);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      model_reset();
      chk("midexec_pc", int'(pc), 0);
      chk("midexec_req", int'(instr_req), 1);
      chk("midexec_retire", int'(retire), 0);
      chk("midexec_halted", int'(halted), 0);
      for (int i = 0; i < NR; i++) begin
         dbg_sel = i[RA-1:0];
         #1;
         chk("midexec_reg", int'(dbg_data), 0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      issue(enc(1, 3, 0, 2), 0);
      issue(enc(2, 4, 0, 3), 2);
      issue(enc(3, 5, 4, 3), 0);
      drain();

      summary_and_end();
   end

   // Global bound so the run always ends.
   initial begin : watchdog
      #500000;
      n_cmp++; n_fail++;
      $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
      summary_and_end();
   end

endmodule
`default_nettype wire
